// File: rtl/regfile_wb_sched_if.sv
// Write-back scheduler bus: two producer handshakes, scoreboard alloc/decode
// lookups, and the registered regfile write port.
interface regfile_wb_sched_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            alloc_valid;
    logic [AW-1:0]   alloc_rd;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            stall;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            regwen;
    logic            err_realloc;

    // Pipeline side: producers, issue and decode
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output alloc_valid, alloc_rd, rs1_addr, rs2_addr,
        input  alu_ready, lsu_ready, stall, waddr, wdata, regwen, err_realloc
    );

    // Scheduler side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  alloc_valid, alloc_rd, rs1_addr, rs2_addr,
        output alu_ready, lsu_ready, stall, waddr, wdata, regwen, err_realloc
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the regfile's single write port. Arbitrates ALU
// (req 0) and LSU (req 1) results onto a registered write port and keeps a
// per-register busy scoreboard that drives the decode stall.
module regfile_wb_sched #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sched_if.slave  bus
);
    // r_rr_last: 1 = LSU won the most recent transfer, 0 = ALU did
    logic            r_rr_last;
    logic            r_regwen;
    logic [AW-1:0]   r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic [NREG-1:0] r_busy;
    logic            r_err;

    logic            w_alu_gnt;
    logic            w_lsu_gnt;
    logic            w_xfer;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    logic            w_set;
    logic            w_clr;
    logic            w_err;
    logic [NREG-1:0] w_busy_nxt;

    // Grant: lone requester wins; on a tie RR picks the one that did not go last
    always_comb begin
        w_alu_gnt = 1'b0;
        w_lsu_gnt = 1'b0;
        if (rst) begin
            if (bus.alu_valid && bus.lsu_valid) begin
                if (RR_EN && r_rr_last) w_alu_gnt = 1'b1;
                else                    w_lsu_gnt = 1'b1;
            end else begin
                w_alu_gnt = bus.alu_valid;
                w_lsu_gnt = bus.lsu_valid;
            end
        end
    end

    assign bus.alu_ready = w_alu_gnt;
    assign bus.lsu_ready = w_lsu_gnt;
    assign w_xfer        = w_alu_gnt || w_lsu_gnt;
    assign w_rd          = w_lsu_gnt ? bus.lsu_rd   : bus.alu_rd;
    assign w_data        = w_lsu_gnt ? bus.lsu_data : bus.alu_data;

    // Write port register; rd==0 transfers are consumed without a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwen  <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_rr_last <= 1'b1;
        end else begin
            r_regwen <= w_xfer && (w_rd != '0);
            if (w_xfer) begin
                r_waddr   <= w_rd;
                r_wdata   <= w_data;
                r_rr_last <= w_lsu_gnt;
            end
        end
    end

    // Scoreboard next state: clear on the landing write, then set (set wins)
    assign w_clr = r_regwen && (r_waddr != '0);
    assign w_set = bus.alloc_valid && (bus.alloc_rd != '0);
    assign w_err = w_set && r_busy[bus.alloc_rd] && !(w_clr && (r_waddr == bus.alloc_rd));

    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (w_clr && (r_waddr == AW'(i)))      w_busy_nxt[i] = 1'b0;
            if (w_set && (bus.alloc_rd == AW'(i))) w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector and sticky realloc error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_err) r_err <= 1'b1;
        end
    end

    assign bus.stall = ((bus.rs1_addr != '0) && r_busy[bus.rs1_addr]) ||
                       ((bus.rs2_addr != '0) && r_busy[bus.rs2_addr]);

    assign bus.waddr       = r_waddr;
    assign bus.wdata       = r_wdata;
    assign bus.regwen      = r_regwen;
    assign bus.err_realloc = r_err;
endmodule
